cam_pix_capture: RTL and testbench

Receives the stereo camera's parallel video interface (FVAL/LVAL/DVAL, DATA_L/DATA_R) in the camera clock domain. It aligns capture to frame boundaries and converts accepted pixels into a valid/ready stream tagged with start-of-frame and end-of-line markers. A small FIFO decouples the camera from the downstream consumer, and the block reports measured frame geometry plus sticky error flags. It sits directly behind the camera pins, ahead of the line buffers feeding the VGA path.

---
 rtl/cam_pix_capture_pkg.sv | 32 +++
 rtl/cam_pix_fifo.sv | 47 ++++
 rtl/cam_pix_capture.sv | 222 ++++++++++++++++++++++
 tb/tb_cam_pix_capture.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pix_capture_pkg.sv
// Shared capture-state enumeration and stream-word layout for cam_pix_capture.
package cam_pix_capture_pkg;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_WAIT,
    ST_ACTIVE,
    ST_DROP
  } cap_state_t;

  // Stream word is {sof, eol, data_l, data_r}; flags sit above the pixel data.
  localparam int FLAG_BITS = 2;
  localparam int EOL_OFS   = 0;
  localparam int SOF_OFS   = 1;

  function automatic int data_width(input int pixel_width);
    return 2 * pixel_width;
  endfunction

  function automatic int word_width(input int pixel_width);
    return data_width(pixel_width) + FLAG_BITS;
  endfunction

  function automatic int eol_bit(input int pixel_width);
    return data_width(pixel_width) + EOL_OFS;
  endfunction

  function automatic int sof_bit(input int pixel_width);
    return data_width(pixel_width) + SOF_OFS;
  endfunction

endpackage

// File: rtl/cam_pix_fifo.sv
// Synchronous show-ahead FIFO; dout presents the head word while not empty.
module cam_pix_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/cam_pix_capture.sv
// Camera parallel-video capture: frame-aligned pixel stream plus geometry/overflow status.
// Define CAM_GEOM_CHECK_EN to compare measured line/frame geometry against HACT/VACT.
module cam_pix_capture
  import cam_pix_capture_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int HACT        = 320,
  parameter int VACT        = 480,
  parameter int FIFO_DEPTH  = 16,
  parameter int CNT_WIDTH   = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fval,
  input  logic                     lval,
  input  logic                     dval,
  input  logic [PIXEL_WIDTH-1:0]   data_l,
  input  logic [PIXEL_WIDTH-1:0]   data_r,
  input  logic                     clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*PIXEL_WIDTH-1:0] out_data,
  output logic                     out_sof,
  output logic                     out_eol,
  output logic                     frame_done,
  output logic [CNT_WIDTH-1:0]     pix_count,
  output logic [CNT_WIDTH-1:0]     line_count,
  output logic                     overflow,
  output logic                     geom_err
);

  localparam int DW      = data_width(PIXEL_WIDTH);
  localparam int WW      = word_width(PIXEL_WIDTH);
  localparam int EOL_BIT = eol_bit(PIXEL_WIDTH);
  localparam int SOF_BIT = sof_bit(PIXEL_WIDTH);

  cap_state_t           state, state_nxt;
  logic                 s1_fval, s1_lval, s1_dval, s1_live, fval_prev;
  logic [DW-1:0]        s1_data;
  logic                 hold_valid, hold_sof, sof_pending;
  logic [DW-1:0]        hold_data;
  logic [CNT_WIDTH-1:0] pix_cnt, line_cnt, pix_inc, line_nxt;
  logic                 fval_rise, fval_fall, frame_start, s1_acc, line_end, capture;
  logic                 push_req, push, eol_push, overflow_evt, load, sof_now;
  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [WW-1:0]        fifo_din, fifo_dout;

  // s1_live keeps SYNC from trusting the reset value of s1_fval.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_fval   <= 1'b0;
      s1_lval   <= 1'b0;
      s1_dval   <= 1'b0;
      s1_data   <= '0;
      s1_live   <= 1'b0;
      fval_prev <= 1'b0;
    end else begin
      s1_fval   <= fval;
      s1_lval   <= lval;
      s1_dval   <= dval;
      s1_data   <= {data_l, data_r};
      s1_live   <= 1'b1;
      fval_prev <= s1_fval;
    end
  end

  assign fval_rise   = s1_fval && !fval_prev;
  assign fval_fall   = !s1_fval && fval_prev;
  assign frame_start = (state == ST_WAIT) && fval_rise;
  assign s1_acc      = s1_fval && s1_lval && s1_dval;
  assign line_end    = !s1_lval || !s1_fval;
  assign capture     = (state == ST_ACTIVE) || frame_start;

  assign push_req     = capture && hold_valid && (s1_acc || line_end);
  assign overflow_evt = push_req && fifo_full;
  assign push         = push_req && !fifo_full;
  assign eol_push     = push && !s1_acc;
  assign load         = capture && s1_acc && !overflow_evt;
  assign sof_now      = sof_pending || (state == ST_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_SYNC;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    case (state)
      ST_SYNC:   if (s1_live && !s1_fval) state_nxt = ST_WAIT;
      ST_WAIT:   if (fval_rise) state_nxt = ST_ACTIVE;
      ST_ACTIVE: begin
        if (fval_fall) begin
          state_nxt  = ST_WAIT;
          frame_done = 1'b1;
        end else if (overflow_evt) begin
          state_nxt = ST_DROP;
        end
      end
      ST_DROP: begin
        if (fval_fall) begin
          state_nxt  = ST_WAIT;
          frame_done = 1'b1;
        end
      end
      default: state_nxt = ST_SYNC;
    endcase
  end

  // The held pixel is only released once stage 1 reveals whether it ends the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid  <= 1'b0;
      hold_sof    <= 1'b0;
      hold_data   <= '0;
      sof_pending <= 1'b0;
    end else if ((state == ST_DROP) || overflow_evt) begin
      hold_valid  <= 1'b0;
      sof_pending <= 1'b0;
    end else if (load) begin
      hold_valid  <= 1'b1;
      hold_data   <= s1_data;
      hold_sof    <= sof_now;
      sof_pending <= 1'b0;
    end else begin
      if (eol_push) begin
        hold_valid <= 1'b0;
      end
      if (frame_start) begin
        sof_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    fifo_din          = '0;
    fifo_din[DW-1:0]  = hold_data;
    fifo_din[EOL_BIT] = !s1_acc;
    fifo_din[SOF_BIT] = hold_sof;
  end

  assign pix_inc  = (pix_cnt == '1) ? pix_cnt : pix_cnt + CNT_WIDTH'(1);
  assign line_nxt = (eol_push && (line_cnt != '1)) ? line_cnt + CNT_WIDTH'(1) : line_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt    <= '0;
      line_cnt   <= '0;
      pix_count  <= '0;
      line_count <= '0;
    end else if (frame_start) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
    end else begin
      if (eol_push) begin
        pix_cnt   <= '0;
        pix_count <= pix_inc;
      end else if (push) begin
        pix_cnt <= pix_inc;
      end
      if (frame_done) begin
        line_cnt   <= '0;
        line_count <= line_nxt;
      end else begin
        line_cnt <= line_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (overflow_evt) begin
      overflow <= 1'b1;
    end else if (clr) begin
      overflow <= 1'b0;
    end
  end

`ifdef CAM_GEOM_CHECK_EN
  logic geom_set;

  assign geom_set = (eol_push && (pix_inc != CNT_WIDTH'(HACT))) ||
                    (frame_done && (line_nxt != CNT_WIDTH'(VACT)));

  always_ff @(posedge clk) begin
    if (rst) begin
      geom_err <= 1'b0;
    end else if (geom_set) begin
      geom_err <= 1'b1;
    end else if (clr) begin
      geom_err <= 1'b0;
    end
  end
`else
  assign geom_err = 1'b0;
`endif

  assign fifo_pop  = out_valid && out_ready;
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_dout[DW-1:0];
  assign out_eol   = fifo_dout[EOL_BIT];
  assign out_sof   = fifo_dout[SOF_BIT];

  cam_pix_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_cam_pix_capture.sv
// Directed bench for cam_pix_capture: table-driven frame shapes plus reset/overflow sequences.
module tb_cam_pix_capture;

  localparam int PW = 8;
  localparam int CW = 12;
  localparam int DW = 2 * PW;
`ifdef CAM_GEOM_CHECK_EN
  localparam logic GE = 1'b1;
`else
  localparam logic GE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, fval, lval, dval, clr, out_ready;
  logic [PW-1:0] data_l, data_r;
  logic          out_valid, out_sof, out_eol, frame_done, overflow, geom_err;
  logic [DW-1:0] out_data;
  logic [CW-1:0] pix_count, line_count;

  always #5 clk = ~clk;

  cam_pix_capture #(
    .PIXEL_WIDTH (PW),
    .HACT        (4),
    .VACT        (3),
    .FIFO_DEPTH  (4),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fval       (fval),
    .lval       (lval),
    .dval       (dval),
    .data_l     (data_l),
    .data_r     (data_r),
    .clr        (clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sof    (out_sof),
    .out_eol    (out_eol),
    .frame_done (frame_done),
    .pix_count  (pix_count),
    .line_count (line_count),
    .overflow   (overflow),
    .geom_err   (geom_err)
  );

  typedef struct {
    int   lines;
    int   pix;
    int   gap_line;
    int   gap_pos;
    int   gap_len;
    int   exp_words;
    int   exp_pix;
    int   exp_lines;
    logic exp_geom;
    logic chk_lat;
  } vec_t;

  vec_t          vecs[4];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            fd_count = 0;
  int            exp_first_cyc, exp_last_cyc;
  logic [DW+1:0] got_q[$];
  logic [DW+1:0] exp_q[$];
  int            got_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      got_q.push_back({out_sof, out_eol, out_data});
      got_cyc.push_back(cyc);
    end
    if (frame_done) fd_count++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic f, input logic l, input logic d,
                               input logic [PW-1:0] dl, input logic [PW-1:0] dr);
    @(posedge clk);
    #1;
    fval   = f;
    lval   = l;
    dval   = d;
    data_l = dl;
    data_r = dr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic compareStream(input string tag, input int n);
    checkOutput({tag, " word count"}, got_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < got_q.size() && i < exp_q.size())
        checkOutput($sformatf("%s word %0d", tag, i), got_q[i], exp_q[i]);
    end
  endtask

  task automatic resetQueues();
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
    fd_count = 0;
  endtask

  task automatic pulseClr();
    clr = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    clr = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  // Sends one frame and records the words the consumer should see.
  task automatic sendFrame(input int lines, input int pix, input int gap_line,
                           input int gap_pos, input int gap_len, input int seed);
    logic [PW-1:0] dl, dr;
    logic          sof, eol;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < pix; p++) begin
        if (l == gap_line && p == gap_pos)
          repeat (gap_len) applyStimulus(1'b1, 1'b1, 1'b0, 8'hEE, 8'hEE);
        dl  = 8'(seed + l * 16 + p);
        dr  = ~dl;
        sof = (l == 0) && (p == 0);
        eol = (p == pix - 1);
        applyStimulus(1'b1, 1'b1, 1'b1, dl, dr);
        if (sof) exp_first_cyc = cyc + 3;
        if (l == lines - 1 && p == pix - 1) exp_last_cyc = cyc + 3;
        exp_q.push_back({sof, eol, dl, dr});
      end
      repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    end
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    vecs[0] = '{3, 4, -1, 0, 0, 12, 4, 3, 1'b0, 1'b1};
    vecs[1] = '{3, 4,  1, 2, 2, 12, 4, 3, 1'b0, 1'b0};
    vecs[2] = '{1, 1, -1, 0, 0,  1, 1, 1, GE,   1'b1};
    vecs[3] = '{2, 5, -1, 0, 0, 10, 5, 2, GE,   1'b0};

    rst = 1'b1; clr = 1'b0; out_ready = 1'b1;
    fval = 1'b1; lval = 1'b1; dval = 1'b1; data_l = 8'h5A; data_r = 8'hA5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset out_sof", out_sof, 0);
    checkOutput("reset out_eol", out_eol, 0);
    checkOutput("reset frame_done", frame_done, 0);
    checkOutput("reset overflow", overflow, 0);
    checkOutput("reset geom_err", geom_err, 0);
    checkOutput("reset out_data", out_data, 0);
    checkOutput("reset pix_count", pix_count, 0);
    checkOutput("reset line_count", line_count, 0);
    rst = 1'b0;

    // Leave reset in the middle of a frame; nothing may be captured from it.
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, (i % 5) != 4, 1'b1, 8'(i), 8'(~i));
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("partial frame words", got_q.size(), 0);
    checkOutput("partial frame frame_done", fd_count, 0);

    for (int r = 0; r < 4; r++) begin
      pulseClr();
      resetQueues();
      sendFrame(vecs[r].lines, vecs[r].pix, vecs[r].gap_line, vecs[r].gap_pos,
                vecs[r].gap_len, 32 + r * 64);
      compareStream($sformatf("row%0d", r), vecs[r].exp_words);
      checkOutput($sformatf("row%0d frame_done", r), fd_count, 1);
      checkOutput($sformatf("row%0d pix_count", r), pix_count, vecs[r].exp_pix);
      checkOutput($sformatf("row%0d line_count", r), line_count, vecs[r].exp_lines);
      checkOutput($sformatf("row%0d geom_err", r), geom_err, vecs[r].exp_geom);
      checkOutput($sformatf("row%0d overflow", r), overflow, 0);
      if (vecs[r].chk_lat && got_cyc.size() == vecs[r].exp_words) begin
        checkOutput($sformatf("row%0d first latency", r), got_cyc[0], exp_first_cyc);
        checkOutput($sformatf("row%0d last latency", r),
                    got_cyc[got_cyc.size() - 1], exp_last_cyc);
      end
    end

    // Overflow: consumer stalled through a 12-pixel frame with a 4-entry FIFO.
    pulseClr();
    resetQueues();
    out_ready = 1'b0;
    sendFrame(3, 4, -1, 0, 0, 8'h10);
    checkOutput("ovf overflow set", overflow, 1);
    checkOutput("ovf frame_done", fd_count, 1);
    checkOutput("ovf out_valid held", out_valid, 1);
    checkOutput("ovf out_data held", out_data, exp_q[0][DW-1:0]);
    checkOutput("ovf out_sof held", out_sof, 1);
    out_ready = 1'b1;
    repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    compareStream("ovf drain", 4);
    checkOutput("ovf overflow sticky", overflow, 1);
    resetQueues();
    sendFrame(3, 4, -1, 0, 0, 8'h70);
    compareStream("ovf next frame", 12);
    checkOutput("ovf next pix_count", pix_count, 4);
    pulseClr();
    checkOutput("ovf clr", overflow, 0);

    // Reset pulse during line 2, then recover on the following frame.
    resetQueues();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int p = 0; p < 4; p++) applyStimulus(1'b1, 1'b1, 1'b1, 8'(p), 8'(~p));
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int p = 0; p < 2; p++) applyStimulus(1'b1, 1'b1, 1'b1, 8'(p + 16), 8'(~(p + 16)));
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h33, 8'hCC);
    @(negedge clk);
    checkOutput("rst mid out_valid", out_valid, 0);
    checkOutput("rst mid frame_done", frame_done, 0);
    checkOutput("rst mid pix_count", pix_count, 0);
    checkOutput("rst mid line_count", line_count, 0);
    checkOutput("rst mid out_data", out_data, 0);
    rst = 1'b0;
    resetQueues();
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h34, 8'hCB);
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int p = 0; p < 4; p++) applyStimulus(1'b1, 1'b1, 1'b1, 8'(p + 32), 8'(~(p + 32)));
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("rst tail words", got_q.size(), 0);
    checkOutput("rst tail frame_done", fd_count, 0);
    sendFrame(3, 4, -1, 0, 0, 8'h90);
    compareStream("rst recover", 12);
    checkOutput("rst recover frame_done", fd_count, 1);
    checkOutput("rst recover pix_count", pix_count, 4);
    checkOutput("rst recover line_count", line_count, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
